// File: rtl/eth_axi_fifo_bridge.sv
// AXI4 slave exposing one packet FIFO: write bursts push beats, read bursts pop them.
// Addresses are ignored; read underflow returns SLVERR beats instead of stalling.
module eth_axi_fifo_bridge #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   awid,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    wstate_t           r_wstate;
    logic              r_awready;
    logic [ID_W-1:0]   r_bid;
    logic [7:0]        r_awlen;
    logic [7:0]        r_wbeat;
    logic              r_werr;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    rstate_t           r_rstate;
    logic              r_arready;
    logic [ID_W-1:0]   r_rid;
    logic [7:0]        r_arlen;
    logic [7:0]        r_rbeat;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [DATA_W-1:0] r_rdata;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_final_beat;
    logic w_beat_err;

    // Flags come only from the registered count, so wready has no input-to-output path.
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = (r_wstate == W_DATA) && wvalid && !w_full;
    assign w_pop        = (r_rstate == R_FETCH) && !w_empty;
    assign w_final_beat = (r_wbeat == r_awlen);
    assign w_beat_err   = (wlast != w_final_beat);

    assign awready    = r_awready;
    assign wready     = (r_wstate == W_DATA) && !w_full;
    assign bid        = r_bid;
    assign bresp      = r_bresp;
    assign bvalid     = r_bvalid;
    assign arready    = r_arready;
    assign rid        = r_rid;
    assign rdata      = r_rdata;
    assign rresp      = r_rresp;
    assign rlast      = r_rlast;
    assign rvalid     = r_rvalid;
    assign fifo_count = r_count;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst length is fixed by awlen; wlast only feeds the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_bid     <= '0;
            r_awlen   <= '0;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid && r_awready) begin
                        r_bid     <= awid;
                        r_awlen   <= awlen;
                        r_wbeat   <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_push) begin
                        r_wbeat <= r_wbeat + 8'd1;
                        if (w_beat_err) begin
                            r_werr <= 1'b1;
                        end
                        if (w_final_beat) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_beat_err) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // An empty FIFO yields a zero SLVERR beat rather than a stall, so a reader can never deadlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rid     <= '0;
            r_arlen   <= '0;
            r_rbeat   <= '0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_rid     <= arid;
                        r_arlen   <= arlen;
                        r_rbeat   <= '0;
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    if (!w_empty) begin
                        r_rdata <= r_mem[r_rd_ptr];
                        r_rresp <= 2'b00;
                    end else begin
                        r_rdata <= '0;
                        r_rresp <= 2'b10;
                    end
                    r_rlast  <= (r_rbeat == r_arlen);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_SEND;
                end
                R_SEND: begin
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rbeat  <= r_rbeat + 8'd1;
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_axi_fifo_bridge.sv
// Scoreboard bench for eth_axi_fifo_bridge: a queue model predicts R/B responses,
// a negedge monitor compares every handshake and tracks occupancy.
module tb_eth_axi_fifo_bridge;

    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LIMIT  = 400;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   awid = '0;
    logic [7:0]        awlen = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic              wlast = 1'b0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [ID_W-1:0]   arid = '0;
    logic [7:0]        arlen = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    always #5 clk = ~clk;

    eth_axi_fifo_bridge #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_exp_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_exp_t;

    logic [DATA_W-1:0] model_q[$];
    r_exp_t            exp_r[$];
    b_exp_t            exp_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    bit hold_r     = 1'b0;
    bit rand_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rready = hold_r ? 1'b0 : (rand_ready ? 1'($urandom % 2) : 1'b1);
            bready = rand_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, R hold stability, occupancy tracking from observed pushes/pops
    int     cnt_trk   = 0;
    int     exp_cnt   = 0;
    bit     push_prev = 1'b0;
    bit     rv_prev   = 1'b0;
    bit     hold_seen = 1'b0;
    r_exp_t sv_r;
    r_exp_t e_r;
    b_exp_t e_b;

    always @(negedge clk) begin
        if (rst) begin
            cnt_trk   = 0;
            push_prev = 1'b0;
            rv_prev   = 1'b0;
            hold_seen = 1'b0;
        end else begin
            exp_cnt = cnt_trk + int'(push_prev) - ((rvalid && !rv_prev && rresp == 2'b00) ? 1 : 0);
            chk("count_track", 64'(fifo_count), 64'(exp_cnt));
            chk("empty_flag", 64'(fifo_empty), 64'(exp_cnt == 0));
            chk("full_flag", 64'(fifo_full), 64'(exp_cnt == DEPTH));
            cnt_trk   = exp_cnt;
            push_prev = wvalid && wready;
            rv_prev   = rvalid;

            if (hold_seen) begin
                chk("r_hold_valid", 64'(rvalid), 64'd1);
                chk("r_hold_data", 64'(rdata), 64'(sv_r.data));
                chk("r_hold_resp", 64'(rresp), 64'(sv_r.resp));
                chk("r_hold_last", 64'(rlast), 64'(sv_r.last));
                chk("r_hold_id", 64'(rid), 64'(sv_r.id));
            end
            hold_seen = rvalid && !rready;
            if (hold_seen) begin
                sv_r.data = rdata;
                sv_r.resp = rresp;
                sv_r.last = rlast;
                sv_r.id   = rid;
            end

            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 64'(rvalid), 64'd0);
                end else begin
                    e_r = exp_r.pop_front();
                    chk("r_id", 64'(rid), 64'(e_r.id));
                    chk("r_data", 64'(rdata), 64'(e_r.data));
                    chk("r_resp", 64'(rresp), 64'(e_r.resp));
                    chk("r_last", 64'(rlast), 64'(e_r.last));
                end
            end

            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 64'(bvalid), 64'd0);
                end else begin
                    e_b = exp_b.pop_front();
                    chk("b_id", 64'(bid), 64'(e_b.id));
                    chk("b_resp", 64'(bresp), 64'(e_b.resp));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: correct wlast, 1: wlast on every beat, 2: random wlast
    task automatic write_burst(input logic [ID_W-1:0] id, input int len,
                               input logic [DATA_W-1:0] base, input bit rnd, input int mode);
        logic [DATA_W-1:0] d[256];
        bit                wl[256];
        bit                err;
        b_exp_t            eb;
        int                t;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d[i] = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
            case (mode)
                0:       wl[i] = (i == len);
                1:       wl[i] = 1'b1;
                default: wl[i] = 1'($urandom % 2);
            endcase
            if (wl[i] != (i == len)) err = 1'b1;
            model_q.push_back(d[i]);
        end
        eb.id   = id;
        eb.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(eb);

        awid = id; awlen = 8'(len); awvalid = 1'b1;
        t = 0;
        while (!awready && t < LIMIT) begin step(); t++; end
        if (t >= LIMIT) chk("aw_timeout", 64'(awready), 64'd1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = d[i]; wlast = wl[i];
            t = 0;
            while (!wready && t < LIMIT) begin step(); t++; end
            if (t >= LIMIT) chk("w_timeout", 64'(wready), 64'd1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_latency", 64'(bvalid), 64'd1);
        t = 0;
        while (exp_b.size() != 0 && t < LIMIT) begin step(); t++; end
        if (t >= LIMIT) chk("b_drain_timeout", 64'(exp_b.size()), 64'd0);
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input int len);
        r_exp_t e;
        int     t;
        for (int i = 0; i <= len; i++) begin
            e.id = id;
            if (model_q.size() > 0) begin
                e.data = model_q.pop_front();
                e.resp = 2'b00;
            end else begin
                e.data = '0;
                e.resp = 2'b10;
            end
            e.last = (i == len);
            exp_r.push_back(e);
        end
        arid = id; arlen = 8'(len); arvalid = 1'b1;
        t = 0;
        while (!arready && t < LIMIT) begin step(); t++; end
        if (t >= LIMIT) chk("ar_timeout", 64'(arready), 64'd1);
        step();
        arvalid = 1'b0;
        chk("r_lat_fetch", 64'(rvalid), 64'd0);
        step();
        chk("r_lat_send", 64'(rvalid), 64'd1);
        t = 0;
        while (exp_r.size() != 0 && t < LIMIT) begin step(); t++; end
        if (t >= LIMIT) chk("r_drain_timeout", 64'(exp_r.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'd1);
        chk({tag, "_arready"}, 64'(arready), 64'd1);
        chk({tag, "_wready"}, 64'(wready), 64'd0);
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_rlast"}, 64'(rlast), 64'd0);
        chk({tag, "_bresp"}, 64'(bresp), 64'd0);
        chk({tag, "_rresp"}, 64'(rresp), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_bid"}, 64'(bid), 64'd0);
        chk({tag, "_rid"}, 64'(rid), 64'd0);
        chk({tag, "_count"}, 64'(fifo_count), 64'd0);
        chk({tag, "_empty"}, 64'(fifo_empty), 64'd1);
        chk({tag, "_full"}, 64'(fifo_full), 64'd0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int room;
        int len;

        rst = 1'b1;
        repeat (3) step();
        check_reset_state("reset");
        rst = 1'b0;
        step();

        // Basic 4-beat write then read
        write_burst(8'h3C, 3, 32'hA0, 1'b0, 0);
        chk("t1_count_w", 64'(fifo_count), 64'd4);
        read_burst(8'h5A, 3);
        chk("t1_count_r", 64'(fifo_count), 64'd0);

        // Overfill: 18-beat write blocks at full; a 2-beat read lets it finish
        fork
            write_burst(8'h21, DEPTH + 1, 32'h100, 1'b0, 0);
            begin
                repeat (30) step();
                chk("t2_wready_blocked", 64'(wready), 64'd0);
                chk("t2_full", 64'(fifo_full), 64'd1);
                chk("t2_count_full", 64'(fifo_count), 64'(DEPTH));
                read_burst(8'h77, 1);
            end
        join
        chk("t2_count", 64'(fifo_count), 64'(model_q.size()));
        read_burst(8'h78, DEPTH - 1);
        chk("t2_drained", 64'(fifo_count), 64'd0);

        // Underflow: one word, three-beat read
        write_burst(8'h05, 0, 32'h55, 1'b0, 0);
        read_burst(8'h06, 2);
        chk("t3_count", 64'(fifo_count), 64'd0);

        // Early wlast -> SLVERR, both words still stored
        write_burst(8'h44, 1, 32'hC0, 1'b0, 1);
        chk("t4_count", 64'(fifo_count), 64'd2);
        read_burst(8'h45, 1);

        // Held R beat while writes push; then overlap push with the next fetch
        write_burst(8'h10, 2, 32'h11, 1'b0, 0);
        hold_r = 1'b1;
        fork
            read_burst(8'h12, 1);
            begin
                repeat (4) step();
                chk("t5_count_held", 64'(fifo_count), 64'd2);
                write_burst(8'h13, 2, 32'h31, 1'b0, 0);
                chk("t5_count_pushed", 64'(fifo_count), 64'd5);
                step();
                hold_r = 1'b0;
                write_burst(8'h14, 1, 32'h41, 1'b0, 0);
            end
        join
        chk("t5_count", 64'(fifo_count), 64'(model_q.size()));
        read_burst(8'h15, model_q.size() - 1);

        // Randomised traffic with random ready back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            room = DEPTH - model_q.size();
            if (room > 0 && ($urandom % 2) == 1) begin
                len = $urandom_range(0, ((room < 8) ? room : 8) - 1);
                write_burst(ID_W'($urandom), len, '0, 1'b1, (($urandom % 5) == 0) ? 2 : 0);
            end else begin
                read_burst(ID_W'($urandom), $urandom_range(0, 7));
            end
            chk("rand_count", 64'(fifo_count), 64'(model_q.size()));
        end
        rand_ready = 1'b0;
        step();
        read_burst(8'hEE, DEPTH - 1);
        chk("rand_drained", 64'(fifo_count), 64'd0);

        // Reset in the middle of an 8-beat write and a held read
        hold_r  = 1'b1;
        awid    = 8'h9A; awlen = 8'd7; awvalid = 1'b1;
        arid    = 8'h9B; arlen = 8'd3; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        wvalid  = 1'b1; wdata = 32'hD0; wlast = 1'b0;
        step();
        wdata = 32'hD1;
        step();
        wdata = 32'hD2;
        rst = 1'b1;
        step();
        check_reset_state("rst_mid");
        rst = 1'b0; wvalid = 1'b0; hold_r = 1'b0;
        model_q.delete();
        step();
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_awready", 64'(awready), 64'd1);

        // FIFO usable again after reset
        write_burst(8'h61, 1, 32'hF0, 1'b0, 0);
        read_burst(8'h62, 1);
        chk("final_count", 64'(fifo_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_axi_fifo_bridge.md
Name: eth_axi_fifo_bridge

Overview:
- Parametrised AXI4 slave that exposes one internal packet FIFO through both AXI4 channels.
- Write bursts push beats into the FIFO; read bursts pop beats out of it.
- Addresses are ignored: the FIFO is address-mapped as a single port.
- Next-generation replacement for the fixed-width ETH infifo/outfifo slave ports. Adds configurable width/depth, per-beat error signalling on underflow, burst-length checking, and occupancy status for the ETH CSR block.

Parameters:
- DATA_W, 32: AXI data width and FIFO word width, in bits (32 or 64).
- ID_W, 8: AXI transaction ID width.
- DEPTH, 16: FIFO depth in words; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- awid  in  ID_W  write burst ID
- awlen  in  8  write beats minus 1
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_W  write data
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid  in  ID_W  read burst ID
- arlen  in  8  read beats minus 1
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  read ID
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- fifo_count  out  CNT_W  words stored
- fifo_full  out  1  fifo_count == DEPTH
- fifo_empty  out  1  fifo_count == 0

Behaviour:
- Reset: one clock, synchronous active-high rst. Both FSMs go to IDLE and FIFO pointers/count go to 0; contents are discarded, including mid-burst.
- Output reset values: awready=1, arready=1. wready=0, bvalid=0, rvalid=0, rlast=0. bresp=0, rresp=0, rdata=0, bid=0, rid=0. fifo_empty=1, fifo_full=0, fifo_count=0.
- Write FSM, W_IDLE:
  - awready=1.
  - On AW handshake: latch awid and awlen, clear the beat counter, go to W_DATA.
- Write FSM, W_DATA:
  - wready = !fifo_full. A full FIFO back-pressures; data is never dropped.
  - Each W handshake pushes wdata and increments the beat counter.
  - Error flag is set if wlast=1 on a non-final beat, or wlast=0 on the final beat (beat == awlen).
  - The burst always ends on beat awlen; wlast is not used for termination.
  - Go to W_RESP the cycle after the final beat.
- Write FSM, W_RESP:
  - bvalid=1, bid = latched ID, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - bvalid and bresp are held until bready, then go to W_IDLE.
- Read FSM, R_IDLE:
  - arready=1.
  - On AR handshake: latch arid and arlen, clear the beat counter, go to R_FETCH.
- Read FSM, R_FETCH (one cycle, rvalid=0):
  - If the FIFO is non-empty: pop the head into the rdata register, rresp=00.
  - If the FIFO is empty: rdata=0, rresp=10, no pop. The bridge never stalls, to avoid deadlock.
  - rlast = (beat == arlen). Go to R_SEND.
- Read FSM, R_SEND:
  - rvalid=1; rid, rdata, rresp, rlast stay stable until rready.
  - On handshake: if rlast, go to R_IDLE; else increment the beat counter and go to R_FETCH.
- Latency:
  - First rvalid appears 2 cycles after the AR handshake.
  - Sustained read throughput is 1 beat per 2 cycles.
  - Write throughput is 1 beat per cycle while the FIFO is not full.
  - bvalid appears 1 cycle after the final W handshake.
- Read and write FSMs are independent.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - A pop from a full FIFO during a blocked write frees wready on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_count increments on push-only, decrements on pop-only, and never exceeds DEPTH.
- fifo_full and fifo_empty are registered-state derived (no combinational path from AXI inputs). wready depends only on FSM state and fifo_full.

Test Plan:
- Reset, then write awlen=3 with data 0xA0..0xA3 (wlast on beat 3) -> bresp=00, bid matches awid, fifo_count=4. Read arlen=3 -> rdata A0,A1,A2,A3 with rresp=00, rlast only on the 4th beat, fifo_count=0.
- Write DEPTH+2=18 beats (awlen=17) with no reads -> wready drops after 16 beats. Then start a read with arlen=1 -> two pops each re-open wready; bresp=00 after beat 17; fifo_count=16.
- With the FIFO holding 1 word (0x55), read arlen=2 -> beats: 0x55/00, then 0/10, then 0/10 with rlast; fifo_count stays 0.
- Write awlen=1 with wlast asserted on beat 0 and on beat 1 -> 2 words pushed, bresp=10.
- Hold rready=0 for 5 cycles in R_SEND while a write pushes -> rdata, rresp and rlast stay stable; fifo_count rises only from pushes. Concurrent push+pop cycle -> count unchanged.
- Assert rst mid-write (beat 2 of 8) and mid-read -> next cycle awready=1, arready=1, bvalid=0, rvalid=0, fifo_count=0, fifo_empty=1.
